mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage consumer of the EX→MEM stage register outputs. Decodes the latched instruction, runs one load or store per instruction on an external data-memory bus with a req/ack handshake, and stalls the pipeline while the access is outstanding. Delivers aligned and extended load data plus its destination register toward WB.

## Interface
Parameters:
- none; widths come from shared ISA defines: `WORD` = 32 bits, `REG` = 5 bits.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `memInstruction`  in  32  instruction held in the MEM stage register
- `memAluOut`  in  32  effective byte address
- `memMemWriteData`  in  32  store data (rt value)
- `memWriteReg`  in  5  load destination register
- `memMemRead`  in  1  load qualifier from EX
- `memStall`  out  1  freeze upstream stage registers (combinational)
- `busReq`  out  1  access request
- `busWe`  out  1  1 = store
- `busAddr`  out  32  word address, bits [1:0] = 0
- `busWdata`  out  32  lane-replicated store data
- `busByteEn`  out  4  byte lane enables; lane k = bits [8k+7:8k]
- `busAck`  in  1  slave completion, 1-cycle pulse
- `busRdata`  in  32  read data, valid while `busAck`=1
- `wbLoadData`  out  32  extended load result
- `wbLoadReg`  out  5  destination for `wbLoadData`
- `wbLoadValid`  out  1  1-cycle pulse: load result valid
- `addrError`  out  1  1-cycle pulse: misaligned access dropped

## Operation
- Decode `memInstruction[31:26]`:
  - Loads need `memMemRead`=1: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25.
  - Stores: SB 0x28, SH 0x29, SW 0x2B.
  - All other opcodes are non-memory and pass with no stall.
- FSM states: IDLE, REQ, DONE.
  - IDLE, memory op present: latch address, data, size, sign and reg; go to REQ.
  - REQ, `busAck`=1: capture and extend `busRdata` for a load; go to DONE.
  - DONE: go to IDLE unconditionally.
- `memStall` = (IDLE ∧ memory op) ∨ REQ. It is 0 in DONE, so the stage register advances at the end of DONE.
- Bus outputs are driven from registers and are valid only in REQ. `busReq`=1 for every REQ cycle; all other bus outputs are 0 outside REQ.
- Stores:
  - SW: byteEn 1111.
  - SH: byteEn 0011 if addr[1]=0, else 1100; halfword replicated to both halves.
  - SB: byteEn = 1<<addr[1:0]; byte replicated to all four lanes.
- Loads select the lane(s) by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- In DONE after a load: `wbLoadValid`=1 and `wbLoadData`/`wbLoadReg` are valid. `wbLoadValid`=0 after a store.

## Timing
- Reset values: state IDLE; every output 0 except `memStall`, which follows its combinational equation.
- Op in IDLE at cycle N, ack in cycle N+1+k (k ≥ 0 wait cycles):
  - DONE is cycle N+2+k.
  - Stall cycles: N through N+1+k.
  - Minimum occupancy: 3 cycles.
- Back-to-back memory ops: the next op is seen in IDLE the cycle after DONE.
- `busAck` outside REQ is ignored.
- `reset` during REQ returns to IDLE on that edge and drops `busReq` with no completion; the slave must tolerate the abandoned request.
- `reset` during DONE suppresses `wbLoadValid`.

## Configuration
- Macro: `MEM_ALIGN_CHECK_EN`.
- Defined:
  - Misaligned halfword (addr[0]=1) or word (addr[1:0]≠0) goes IDLE→DONE with no bus transaction.
  - `addrError`=1 in that DONE; `wbLoadValid`=0; stall lasts exactly 1 cycle.
- Undefined:
  - `addrError` is tied 0.
  - Halfword ignores addr[0]; word ignores addr[1:0].

## Structure
- The shared ISA header holds `WORD`, `REG` and the memory opcode constants above.
- Add FSM state encodings and access-size codes (BYTE, HALF, WORD) to the same header.
- One combinational sub-module, `mem_lane_align`: load lane extract/extend and store byte-enable/replication. The FSM stays in the top.

## Test plan
- LW, addr 0x100, ack on first REQ cycle, rdata 0xDEADBEEF → stall 2 cycles; `wbLoadData` 0xDEADBEEF, `wbLoadValid` 1 cycle.
- LB, addr 0x103, rdata 0x80FFFFFF → 0xFFFFFF80. LBU, same address and data → 0x00000080.
- SH, addr 0x202, data 0x1234ABCD, ack after 3 wait cycles:
  - busAddr 0x200, byteEn 1100, busWdata 0xABCDABCD.
  - Stall lasts 5 cycles; no `wbLoadValid`.
- SB to 0x101, data 0x55, immediately followed by LW → byteEn 0010, wdata 0x55555555; LW request starts the cycle after DONE.
- `reset` asserted in the 2nd REQ cycle → next cycle `busReq`=0, state IDLE; a late `busAck` is ignored.
- With `MEM_ALIGN_CHECK_EN` defined: LW at 0x102 → no `busReq`, `addrError` pulse, 1 stall cycle. Without it: bus access at 0x100.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared ISA definitions for the MEM stage: word/register widths, memory opcodes,
// FSM state encodings, access-size codes and the memory-opcode decoder.
package mem_access_unit_pkg;

  localparam int WORD = 32;
  localparam int REG  = 5;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    acc_size_e size;
    logic      sign_ext;
  } mem_dec_t;

  // Loads only count as memory ops when EX qualified them with mem_read.
  function automatic mem_dec_t decode_mem_op(input logic [5:0] opcode, input logic mem_read);
    mem_dec_t d;
    d.is_load  = 1'b0;
    d.is_store = 1'b0;
    d.size     = SZ_WORD;
    d.sign_ext = 1'b0;
    case (opcode)
      OP_LB: begin
        d.is_load  = mem_read;
        d.size     = SZ_BYTE;
        d.sign_ext = 1'b1;
      end
      OP_LH: begin
        d.is_load  = mem_read;
        d.size     = SZ_HALF;
        d.sign_ext = 1'b1;
      end
      OP_LW: begin
        d.is_load = mem_read;
        d.size    = SZ_WORD;
      end
      OP_LBU: begin
        d.is_load = mem_read;
        d.size    = SZ_BYTE;
      end
      OP_LHU: begin
        d.is_load = mem_read;
        d.size    = SZ_HALF;
      end
      OP_SB: begin
        d.is_store = 1'b1;
        d.size     = SZ_BYTE;
      end
      OP_SH: begin
        d.is_store = 1'b1;
        d.size     = SZ_HALF;
      end
      OP_SW: begin
        d.is_store = 1'b1;
        d.size     = SZ_WORD;
      end
      default: begin
        d.is_load  = 1'b0;
        d.is_store = 1'b0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: combinational lane handling for the MEM stage -- load lane
// extract with sign/zero extension, store byte enables and lane replication.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  acc_size_e       size,
  input  logic            sign_ext,
  input  logic [WORD-1:0] store_data,
  input  logic [WORD-1:0] rd_data,
  output logic [3:0]      byte_en,
  output logic [WORD-1:0] wr_data,
  output logic [WORD-1:0] load_data
);

  function automatic logic [WORD-1:0] extend_byte(input logic [7:0] b, input logic sext);
    logic signed [7:0]      b_s;
    logic signed [WORD-1:0] w_s;
    b_s = b;
    w_s = b_s;
    return sext ? w_s : {24'h0, b};
  endfunction

  function automatic logic [WORD-1:0] extend_half(input logic [15:0] h, input logic sext);
    logic signed [15:0]     h_s;
    logic signed [WORD-1:0] w_s;
    h_s = h;
    w_s = h_s;
    return sext ? w_s : {16'h0, h};
  endfunction

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte = 8'h0;
    case (addr_lo)
      2'd0:    rd_byte = rd_data[7:0];
      2'd1:    rd_byte = rd_data[15:8];
      2'd2:    rd_byte = rd_data[23:16];
      default: rd_byte = rd_data[31:24];
    endcase
    rd_half = addr_lo[1] ? rd_data[31:16] : rd_data[15:0];
  end

  // Halfword uses addr[1] only; word ignores the low address bits entirely.
  always_comb begin
    byte_en   = 4'b0000;
    wr_data   = '0;
    load_data = '0;
    case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        wr_data   = {4{store_data[7:0]}};
        load_data = extend_byte(rd_byte, sign_ext);
      end
      SZ_HALF: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_data   = {2{store_data[15:0]}};
        load_data = extend_half(rd_half, sign_ext);
      end
      default: begin
        byte_en   = 4'b1111;
        wr_data   = store_data;
        load_data = rd_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one req/ack bus access per memory instruction, stalls
// the pipeline while it is outstanding. Optional misalignment trap: MEM_ALIGN_CHECK_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [WORD-1:0] memInstruction,
  input  logic [WORD-1:0] memAluOut,
  input  logic [WORD-1:0] memMemWriteData,
  input  logic [REG-1:0]  memWriteReg,
  input  logic            memMemRead,
  output logic            memStall,
  output logic            busReq,
  output logic            busWe,
  output logic [WORD-1:0] busAddr,
  output logic [WORD-1:0] busWdata,
  output logic [3:0]      busByteEn,
  input  logic            busAck,
  input  logic [WORD-1:0] busRdata,
  output logic [WORD-1:0] wbLoadData,
  output logic [REG-1:0]  wbLoadReg,
  output logic            wbLoadValid,
  output logic            addrError
);

  logic [1:0]      state_q, state_d;
  logic            wb_valid_q, wb_valid_d;
  logic [WORD-1:0] addr_q, addr_d;
  logic [WORD-1:0] sdata_q, sdata_d;
  logic [WORD-1:0] load_data_q, load_data_d;
  logic [REG-1:0]  reg_q, reg_d;
  acc_size_e       size_q, size_d;
  logic            sign_q, sign_d;
  logic            we_q, we_d;

  mem_dec_t        dec;
  logic            mem_op;
  logic            misalign;
  logic            in_req;
  logic [3:0]      lane_be;
  logic [WORD-1:0] lane_wdata;
  logic [WORD-1:0] lane_load;
  logic            unused_instr_bits;

  assign unused_instr_bits = ^memInstruction[25:0];

  assign dec    = decode_mem_op(memInstruction[31:26], memMemRead);
  assign mem_op = dec.is_load | dec.is_store;
  assign in_req = (state_q == ST_REQ);

`ifdef MEM_ALIGN_CHECK_EN
  logic addr_err_q, addr_err_d;

  assign misalign = ((dec.size == SZ_HALF) && memAluOut[0]) ||
                    ((dec.size == SZ_WORD) && (memAluOut[1:0] != 2'b00));
  assign addrError = addr_err_q & ~reset;

  always_comb begin
    addr_err_d = 1'b0;
    if ((state_q == ST_IDLE) && mem_op) begin
      addr_err_d = misalign;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
    end
  end
`else
  assign misalign  = 1'b0;
  assign addrError = 1'b0;
`endif

  mem_lane_align u_lane (
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .sign_ext   (sign_q),
    .store_data (sdata_q),
    .rd_data    (busRdata),
    .byte_en    (lane_be),
    .wr_data    (lane_wdata),
    .load_data  (lane_load)
  );

  always_comb begin
    state_d     = state_q;
    wb_valid_d  = 1'b0;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    load_data_d = load_data_q;
    reg_d       = reg_q;
    size_d      = size_q;
    sign_d      = sign_q;
    we_d        = we_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          addr_d  = memAluOut;
          sdata_d = memMemWriteData;
          reg_d   = memWriteReg;
          size_d  = dec.size;
          sign_d  = dec.sign_ext;
          we_d    = dec.is_store;
          state_d = misalign ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (busAck) begin
          if (!we_q) begin
            load_data_d = lane_load;
            wb_valid_d  = 1'b1;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state: reset returns to IDLE and abandons any open request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  // Access operands: only observed through state-qualified outputs, so no reset.
  always_ff @(posedge clk) begin
    addr_q      <= addr_d;
    sdata_q     <= sdata_d;
    load_data_q <= load_data_d;
    reg_q       <= reg_d;
    size_q      <= size_d;
    sign_q      <= sign_d;
    we_q        <= we_d;
  end

  assign memStall = ((state_q == ST_IDLE) && mem_op) || in_req;

  assign busReq    = in_req;
  assign busWe     = in_req & we_q;
  assign busAddr   = in_req ? {addr_q[WORD-1:2], 2'b00} : '0;
  assign busByteEn = in_req ? lane_be : 4'b0000;
  assign busWdata  = (in_req && we_q) ? lane_wdata : '0;

  // A reset landing in DONE suppresses the completion pulse.
  assign wbLoadValid = wb_valid_q & ~reset;
  assign wbLoadData  = wbLoadValid ? load_data_q : '0;
  assign wbLoadReg   = wbLoadValid ? reg_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected bus requests and
// load results; a negedge monitor acting as bus slave pops and compares them.
module tb_mem_access_unit;

  localparam logic [5:0] T_LB  = 6'h20;
  localparam logic [5:0] T_LH  = 6'h21;
  localparam logic [5:0] T_LW  = 6'h23;
  localparam logic [5:0] T_LBU = 6'h24;
  localparam logic [5:0] T_LHU = 6'h25;
  localparam logic [5:0] T_SB  = 6'h28;
  localparam logic [5:0] T_SH  = 6'h29;
  localparam logic [5:0] T_SW  = 6'h2B;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memInstruction;
  logic [31:0] memAluOut;
  logic [31:0] memMemWriteData;
  logic [4:0]  memWriteReg;
  logic        memMemRead;
  logic        memStall;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busByteEn;
  logic        busAck;
  logic [31:0] busRdata;
  logic [31:0] wbLoadData;
  logic [4:0]  wbLoadReg;
  logic        wbLoadValid;
  logic        addrError;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          wait_k;
    logic [31:0] rdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_exp_t;

  bus_exp_t bus_q[$];
  wb_exp_t  wb_q[$];
  int       chk_cnt = 0;
  int       err_cnt = 0;
  int       err_exp = 0;
  bit       ack_force = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk             (clk),
    .reset           (reset),
    .memInstruction  (memInstruction),
    .memAluOut       (memAluOut),
    .memMemWriteData (memMemWriteData),
    .memWriteReg     (memWriteReg),
    .memMemRead      (memMemRead),
    .memStall        (memStall),
    .busReq          (busReq),
    .busWe           (busWe),
    .busAddr         (busAddr),
    .busWdata        (busWdata),
    .busByteEn       (busByteEn),
    .busAck          (busAck),
    .busRdata        (busRdata),
    .wbLoadData      (wbLoadData),
    .wbLoadReg       (wbLoadReg),
    .wbLoadValid     (wbLoadValid),
    .addrError       (addrError)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_bus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                            input logic [31:0] wdata, input int wait_k, input logic [31:0] rdata);
    bus_exp_t e;
    e.addr = addr; e.we = we; e.be = be; e.wdata = wdata; e.wait_k = wait_k; e.rdata = rdata;
    bus_q.push_back(e);
  endtask

  task automatic expect_wb(input logic [31:0] data, input logic [4:0] rd);
    wb_exp_t e;
    e.data = data; e.rd = rd;
    wb_q.push_back(e);
  endtask

  task automatic drive_nop();
    memInstruction  = 32'h0;
    memMemRead      = 1'b0;
    memAluOut       = 32'h0;
    memMemWriteData = 32'h0;
    memWriteReg     = 5'd0;
  endtask

  // Holds the instruction in the stage register until a non-stall cycle, then advances.
  task automatic run_op(input logic [5:0] op, input logic mrd, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] rd, input int exp_stall,
                        input string name);
    int n;
    bit done;
    memInstruction  = {op, 5'd3, rd, 16'h0004};
    memMemRead      = mrd;
    memAluOut       = addr;
    memMemWriteData = sdata;
    memWriteReg     = rd;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (memStall) n++;
      else done = 1'b1;
    end
    if (!done) begin
      chk_cnt++;
      err_cnt++;
      $display("FAIL %s_timeout: stall still high after %0d cycles, expected %0d", name, n, exp_stall);
    end else begin
      check32({name, "_stall_cycles"}, n, exp_stall);
    end
    @(posedge clk);
    #1;
    drive_nop();
  endtask

  initial begin : slave_monitor
    bus_exp_t cur;
    wb_exp_t  w;
    int       wait_cnt;
    bit       req_seen;
    req_seen = 1'b0;
    wait_cnt = 0;
    cur.addr = 0; cur.we = 0; cur.be = 0; cur.wdata = 0; cur.wait_k = 1000; cur.rdata = 0;
    busAck   = 1'b0;
    busRdata = 32'h0;
    forever begin
      @(negedge clk);
      busAck   = 1'b0;
      busRdata = 32'h0;
      if (busReq) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          wait_cnt = 0;
          if (bus_q.size() == 0) begin
            chk_cnt++;
            err_cnt++;
            $display("FAIL bus_unexpected: got request at 0x%08h, expected none", busAddr);
            cur.wait_k = 0;
            cur.rdata  = 32'h0;
          end else begin
            cur = bus_q.pop_front();
            check32("bus_addr", busAddr, cur.addr);
            check32("bus_we", {31'b0, busWe}, {31'b0, cur.we});
            if (cur.we) begin
              check32("bus_byte_en", {28'b0, busByteEn}, {28'b0, cur.be});
              check32("bus_wdata", busWdata, cur.wdata);
            end
          end
        end
        if (wait_cnt == cur.wait_k) begin
          busAck   = 1'b1;
          busRdata = cur.rdata;
        end
        wait_cnt++;
      end else begin
        req_seen = 1'b0;
        check32("bus_idle_addr", busAddr, 32'h0);
        check32("bus_idle_wdata", busWdata, 32'h0);
        check32("bus_idle_ctl", {27'b0, busWe, busByteEn}, 32'h0);
      end
      if (ack_force) busAck = 1'b1;
      if (wbLoadValid) begin
        if (wb_q.size() == 0) begin
          chk_cnt++;
          err_cnt++;
          $display("FAIL wb_unexpected: got load result 0x%08h, expected no result", wbLoadData);
        end else begin
          w = wb_q.pop_front();
          check32("wb_data", wbLoadData, w.data);
          check32("wb_reg", {27'b0, wbLoadReg}, {27'b0, w.rd});
        end
      end
      if (addrError) begin
        chk_cnt++;
        if (err_exp > 0) begin
          err_exp--;
        end else begin
          err_cnt++;
          $display("FAIL addr_error_unexpected: got addrError 1, expected 0");
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    err_cnt++;
    $display("FAIL watchdog: got time limit, expected $finish from stimulus");
    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

  initial begin : stimulus
    reset = 1'b1;
    drive_nop();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_stall", {31'b0, memStall}, 32'h0);
    check32("rst_bus_req", {31'b0, busReq}, 32'h0);
    check32("rst_wb_valid", {31'b0, wbLoadValid}, 32'h0);
    check32("rst_wb_data", wbLoadData, 32'h0);
    check32("rst_wb_reg", {27'b0, wbLoadReg}, 32'h0);
    check32("rst_addr_error", {31'b0, addrError}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    expect_bus(32'h100, 1'b0, 4'h0, 32'h0, 0, 32'hDEADBEEF);
    expect_wb(32'hDEADBEEF, 5'd8);
    run_op(T_LW, 1'b1, 32'h100, 32'h0, 5'd8, 2, "lw");

    expect_bus(32'h100, 1'b0, 4'h0, 32'h0, 0, 32'h80FFFFFF);
    expect_wb(32'hFFFFFF80, 5'd9);
    run_op(T_LB, 1'b1, 32'h103, 32'h0, 5'd9, 2, "lb");

    expect_bus(32'h100, 1'b0, 4'h0, 32'h0, 0, 32'h80FFFFFF);
    expect_wb(32'h00000080, 5'd10);
    run_op(T_LBU, 1'b1, 32'h103, 32'h0, 5'd10, 2, "lbu");

    expect_bus(32'h100, 1'b0, 4'h0, 32'h0, 1, 32'h80010000);
    expect_wb(32'hFFFF8001, 5'd11);
    run_op(T_LH, 1'b1, 32'h102, 32'h0, 5'd11, 3, "lh");

    expect_bus(32'h100, 1'b0, 4'h0, 32'h0, 0, 32'h12348765);
    expect_wb(32'h00008765, 5'd12);
    run_op(T_LHU, 1'b1, 32'h100, 32'h0, 5'd12, 2, "lhu");

    expect_bus(32'h200, 1'b1, 4'b1100, 32'hABCDABCD, 3, 32'h0);
    run_op(T_SH, 1'b0, 32'h202, 32'h1234ABCD, 5'd0, 5, "sh");

    expect_bus(32'h100, 1'b1, 4'b0010, 32'h55555555, 0, 32'h0);
    expect_bus(32'h104, 1'b0, 4'h0, 32'h0, 0, 32'h0BADF00D);
    expect_wb(32'h0BADF00D, 5'd13);
    run_op(T_SB, 1'b0, 32'h101, 32'h00000055, 5'd0, 2, "sb");
    run_op(T_LW, 1'b1, 32'h104, 32'h0, 5'd13, 2, "lw_after_sb");

    expect_bus(32'h300, 1'b1, 4'b1111, 32'hCAFEF00D, 2, 32'h0);
    run_op(T_SW, 1'b0, 32'h300, 32'hCAFEF00D, 5'd0, 4, "sw");

    run_op(6'h00, 1'b0, 32'h100, 32'h0, 5'd4, 0, "non_mem");
    run_op(T_LW, 1'b0, 32'h100, 32'h0, 5'd4, 0, "lw_no_memread");

`ifdef MEM_ALIGN_CHECK_EN
    err_exp++;
    run_op(T_LW, 1'b1, 32'h102, 32'h0, 5'd14, 1, "lw_misaligned");
`else
    expect_bus(32'h100, 1'b0, 4'h0, 32'h0, 0, 32'h11223344);
    expect_wb(32'h11223344, 5'd14);
    run_op(T_LW, 1'b1, 32'h102, 32'h0, 5'd14, 2, "lw_misaligned");
`endif

    // Request abandoned by reset in its second REQ cycle; a late ack must be ignored.
    expect_bus(32'h400, 1'b0, 4'h0, 32'h0, 100, 32'h0);
    memInstruction = {T_LW, 5'd3, 5'd15, 16'h0004};
    memMemRead     = 1'b1;
    memAluOut      = 32'h400;
    memWriteReg    = 5'd15;
    @(negedge clk);
    check32("abort_idle_stall", {31'b0, memStall}, 32'h1);
    @(negedge clk);
    check32("abort_req1", {31'b0, busReq}, 32'h1);
    @(negedge clk);
    check32("abort_req2", {31'b0, busReq}, 32'h1);
    reset = 1'b1;
    drive_nop();
    @(negedge clk);
    check32("abort_req_dropped", {31'b0, busReq}, 32'h0);
    check32("abort_stall_dropped", {31'b0, memStall}, 32'h0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    ack_force = 1'b1;
    @(posedge clk);
    #1;
    ack_force = 1'b0;
    @(negedge clk);
    check32("late_ack_req", {31'b0, busReq}, 32'h0);
    check32("late_ack_stall", {31'b0, memStall}, 32'h0);
    check32("late_ack_wb", {31'b0, wbLoadValid}, 32'h0);
    @(posedge clk);
    #1;

    expect_bus(32'h500, 1'b1, 4'b1111, 32'h89ABCDEF, 0, 32'h0);
    run_op(T_SW, 1'b0, 32'h500, 32'h89ABCDEF, 5'd0, 2, "sw_after_abort");

    repeat (3) @(negedge clk);
    check32("bus_queue_drained", bus_q.size(), 32'h0);
    check32("wb_queue_drained", wb_q.size(), 32'h0);
    check32("addr_error_drained", err_exp, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
